// File: rtl/adder16_seq.sv
// Sequential 16-bit add/subtract unit: one shared 4-bit ripple slice processes
// one nibble per clock, LSB first, then reports overflow/sign/zero flags.
module adder16_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        of,
  output logic        sf,
  output logic        zf,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  cnt;
  logic        carry;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [1:0]  op_q;

  // op[1] selects subtract, op[0] selects the logical (unsigned) overflow rule.
  logic        sub;
  logic        logical;
  logic [3:0]  x_nib;
  logic [3:0]  y_nib;
  logic [3:0]  sum_nib;
  logic [4:0]  c;
  logic [15:0] result_next;

  assign sub     = op_q[1];
  assign logical = op_q[0];

  always_comb begin
    x_nib       = a_q[{cnt, 2'b00} +: 4];
    y_nib       = sub ? ~b_q[{cnt, 2'b00} +: 4] : b_q[{cnt, 2'b00} +: 4];
    c           = 5'd0;
    sum_nib     = 4'd0;
    c[0]        = (cnt == 2'd0) ? sub : carry;
    for (int i = 0; i < 4; i++) begin
      sum_nib[i] = x_nib[i] ^ y_nib[i] ^ c[i];
      c[i+1]     = (x_nib[i] & y_nib[i]) | (c[i] & (x_nib[i] ^ y_nib[i]));
    end
    result_next = result;
    result_next[{cnt, 2'b00} +: 4] = sum_nib;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == 2'd3) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      carry  <= 1'b0;
      a_q    <= 16'd0;
      b_q    <= 16'd0;
      op_q   <= 2'd0;
      result <= 16'd0;
      of     <= 1'b0;
      sf     <= 1'b0;
      zf     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            carry <= 1'b0;
            cnt   <= 2'd0;
          end
        end
        CALC: begin
          result <= result_next;
          carry  <= c[4];
          cnt    <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            sf <= result_next[15];
            zf <= (result_next == 16'd0);
            // c[3] is the carry into bit 15, c[4] the carry out of it.
            of <= logical ? (sub ? ~c[4] : c[4]) : (c[3] ^ c[4]);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_adder16_seq.sv
// Directed plus random checks of adder16_seq against an arithmetic reference
// model: latency, flags, ignored starts, operand isolation and async reset.
module tb_adder16_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        of;
  logic        sf;
  logic        zf;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] ADDA = 2'b00, ADDL = 2'b01, SUBA = 2'b10, SUBL = 2'b11;

  adder16_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .of(of), .sf(sf), .zf(zf),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {of, sf, zf, result} from plain arithmetic.
  function automatic logic [18:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [16:0] wide;
    logic [15:0] r;
    logic        ovf;
    if (o[1]) begin
      wide = {1'b0, x} - {1'b0, y};
      r    = wide[15:0];
      ovf  = o[0] ? (x < y) : ((x[15] != y[15]) && (r[15] != x[15]));
    end else begin
      wide = {1'b0, x} + {1'b0, y};
      r    = wide[15:0];
      ovf  = o[0] ? wide[16] : ((x[15] == y[15]) && (r[15] != x[15]));
    end
    return {ovf, r[15], (r == 16'd0), r};
  endfunction

  task automatic check_outputs(input string tag, input logic [18:0] exp);
    check({tag, "_result"}, {16'd0, result}, {16'd0, exp[15:0]});
    check({tag, "_of"}, {31'd0, of}, {31'd0, exp[18]});
    check({tag, "_sf"}, {31'd0, sf}, {31'd0, exp[17]});
    check({tag, "_zf"}, {31'd0, zf}, {31'd0, exp[16]});
  endtask

  // Issues one operation and checks the full E0..E5 timeline. With inject set,
  // a conflicting start is presented during CALC and must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y, input bit inject);
    logic [18:0] exp;
    int          dones;
    exp   = model(o, x, y);
    dones = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    if (inject) begin
      op = ADDL; a = 16'hFFFF; b = 16'hFFFF;
    end else begin
      start = 1'b0; op = 2'($urandom_range(0, 3)); a = 16'($urandom); b = 16'($urandom);
    end
    check("busy_after_e0", {31'd0, busy}, 32'd1);
    check("done_after_e0", {31'd0, done}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; op = 2'($urandom_range(0, 3)); a = 16'($urandom); b = 16'($urandom);
      end
      if (done) dones++;
      if (k < 4) begin
        check("done_early", {31'd0, done}, 32'd0);
        check("busy_calc", {31'd0, busy}, 32'd1);
      end
    end
    check("done_after_e4", {31'd0, done}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd1);
    check_outputs("op", exp);
    @(posedge clk);
    @(negedge clk);
    if (done) dones++;
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("done_count", dones, 32'd1);
    check_outputs("hold", exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0; a = 16'd0; b = 16'd0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check_outputs("rst", 19'd0);
    // start held during reset must be ignored
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_start_ignored", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst = 1'b0;

    run_op(ADDA, 16'h7FFF, 16'h0001, 1'b0);
    run_op(ADDL, 16'hFFFF, 16'h0001, 1'b0);
    run_op(SUBA, 16'h8000, 16'h0001, 1'b0);
    run_op(SUBL, 16'h0001, 16'h0002, 1'b0);
    run_op(SUBL, 16'h0005, 16'h0005, 1'b0);
    run_op(ADDL, 16'h1234, 16'h1111, 1'b1);
    run_op(ADDA, 16'h8000, 16'h8000, 1'b0);
    run_op(SUBA, 16'h7FFF, 16'hFFFF, 1'b0);
    run_op(ADDL, 16'h0000, 16'h0000, 1'b0);

    // Abort mid-operation: reset after nibble 1 is written.
    @(negedge clk);
    start = 1'b1; op = ADDA; a = 16'h1111; b = 16'h2222;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    check("pre_abort_partial", {24'd0, result[7:0]}, 32'h33);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check_outputs("abort", 19'd0);
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_done_held", {31'd0, done}, 32'd0);
    check("abort_busy_held", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst = 1'b0;
    run_op(ADDA, 16'h0001, 16'h0002, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
